// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regbank_pkg
// Description : Shared constants, state type and helpers for the register
//               bank write-port scheduler.
// Revision    : 1.0  initial release
// ============================================================================
package regbank_pkg;

   localparam logic [1:0] WR_FULL = 2'b00;
   localparam logic [1:0] WR_LO   = 2'b01;
   localparam logic [1:0] WR_HI   = 2'b10;
   localparam logic [1:0] WR_PC   = 2'b11;

   localparam int LINK_REG = 15;

   localparam int REQ_ALU = 0;
   localparam int REQ_LD  = 1;
   localparam int REQ_IMM = 2;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_IMM_LO = 1'b1
   } sched_state_e;

   // Successor in the 0 -> 1 -> 2 -> 0 rotation.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regwr_sched_rr_arb3.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb3
// Description : Three-way round-robin arbiter; the pointer names the
//               highest-priority requester and advances past each grant.
// Revision    : 1.0  initial release
// ============================================================================
module rr_arb3
   import regbank_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic       en,
   output logic [2:0] gnt,
   output logic       upd
);

   logic [1:0] r_ptr;
   logic [1:0] w_sel;
   logic [1:0] w_cand;
   logic       w_hit;

   always_comb begin
      gnt    = 3'b000;
      w_sel  = r_ptr;
      w_hit  = 1'b0;
      w_cand = r_ptr;
      for (int k = 0; k < 3; k++) begin
         if (en && !w_hit && req[w_cand]) begin
            gnt[w_cand] = 1'b1;
            w_sel       = w_cand;
            w_hit       = 1'b1;
         end
         w_cand = rr_next(w_cand);
      end
   end

   assign upd = w_hit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr <= 2'd0;
      end else if (w_hit) begin
         r_ptr <= rr_next(w_sel);
      end
   end

endmodule
`default_nettype wire

// File: rtl/regwr_sched.sv
`default_nettype none
// ============================================================================
// Module      : regwr_sched
// Description : Arbitrates the register bank write port between ALU, load,
//               immediate (two half beats) and link requesters.
// Revision    : 1.0  initial release
// ============================================================================
module regwr_sched
   import regbank_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              imm_valid,
   output logic              imm_ready,
   input  logic [ADDR_W-1:0] imm_addr,
   input  logic [DATA_W-1:0] imm_data,
   input  logic              lnk_valid,
   output logic              lnk_ready,
   input  logic [DATA_W-1:0] lnk_pc,
   output logic              wr_en,
   output logic [1:0]        wr_mode,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] wr_pc,
   output logic              pend_valid,
   output logic [ADDR_W-1:0] pend_addr
);

   localparam int HALF_W = DATA_W / 2;

   sched_state_e      r_state;
   sched_state_e      w_state_nxt;
   logic              w_idle;
   logic              w_arb_en;
   logic              w_arb_upd;
   logic [2:0]        w_gnt;
   logic [HALF_W-1:0] r_imm_lo;
   logic [ADDR_W-1:0] r_imm_addr;

   logic              r_wr_en,    w_nxt_en;
   logic [1:0]        r_wr_mode,  w_nxt_mode;
   logic [ADDR_W-1:0] r_wr_addr,  w_nxt_addr;
   logic [DATA_W-1:0] r_wr_data,  w_nxt_data;
   logic [DATA_W-1:0] r_wr_pc,    w_nxt_pc;
   logic              r_pend_v,   w_nxt_pend_v;
   logic [ADDR_W-1:0] r_pend_a,   w_nxt_pend_a;

   // Link bypasses the rotation entirely, so the arbiter is blocked whenever it asks.
   assign w_idle    = rst_n && (r_state == ST_IDLE);
   assign w_arb_en  = w_idle && !lnk_valid;
   assign lnk_ready = w_idle && lnk_valid;

   rr_arb3 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({imm_valid, ld_valid, alu_valid}),
      .en    (w_arb_en),
      .gnt   (w_gnt),
      .upd   (w_arb_upd)
   );

   assign alu_ready = w_gnt[REQ_ALU];
   assign ld_ready  = w_gnt[REQ_LD];
   assign imm_ready = w_gnt[REQ_IMM];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (imm_ready) w_state_nxt = ST_IMM_LO;
         ST_IMM_LO: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_nxt_en     = 1'b0;
      w_nxt_mode   = r_wr_mode;
      w_nxt_addr   = r_wr_addr;
      w_nxt_data   = r_wr_data;
      w_nxt_pc     = r_wr_pc;
      w_nxt_pend_v = 1'b0;
      w_nxt_pend_a = r_pend_a;
      if (r_state == ST_IMM_LO) begin
         w_nxt_en   = 1'b1;
         w_nxt_mode = WR_LO;
         w_nxt_addr = r_imm_addr;
         w_nxt_data = {{HALF_W{1'b0}}, r_imm_lo};
      end else if (lnk_ready) begin
         w_nxt_en   = 1'b1;
         w_nxt_mode = WR_PC;
         w_nxt_addr = ADDR_W'(LINK_REG);
         w_nxt_data = '0;
         w_nxt_pc   = lnk_pc;
      end else if (alu_ready) begin
         w_nxt_en   = 1'b1;
         w_nxt_mode = WR_FULL;
         w_nxt_addr = alu_addr;
         w_nxt_data = alu_data;
      end else if (ld_ready) begin
         w_nxt_en   = 1'b1;
         w_nxt_mode = WR_FULL;
         w_nxt_addr = ld_addr;
         w_nxt_data = ld_data;
      end else if (imm_ready) begin
         w_nxt_en     = 1'b1;
         w_nxt_mode   = WR_HI;
         w_nxt_addr   = imm_addr;
         w_nxt_data   = {{HALF_W{1'b0}}, imm_data[DATA_W-1:HALF_W]};
         w_nxt_pend_v = 1'b1;
         w_nxt_pend_a = imm_addr;
      end
   end

   // A reset here deliberately drops the pending low-half beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_en    <= 1'b0;
         r_wr_mode  <= WR_FULL;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_wr_pc    <= '0;
         r_pend_v   <= 1'b0;
         r_pend_a   <= '0;
         r_imm_lo   <= '0;
         r_imm_addr <= '0;
      end else begin
         r_wr_en   <= w_nxt_en;
         r_wr_mode <= w_nxt_mode;
         r_wr_addr <= w_nxt_addr;
         r_wr_data <= w_nxt_data;
         r_wr_pc   <= w_nxt_pc;
         r_pend_v  <= w_nxt_pend_v;
         r_pend_a  <= w_nxt_pend_a;
         if (imm_ready) begin
            r_imm_lo   <= imm_data[HALF_W-1:0];
            r_imm_addr <= imm_addr;
         end
      end
   end

   assign wr_en      = r_wr_en;
   assign wr_mode    = r_wr_mode;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign wr_pc      = r_wr_pc;
   assign pend_valid = r_pend_v;
   assign pend_addr  = r_pend_a;

endmodule
`default_nettype wire

// File: tb/tb_regwr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_regwr_sched
// Description : Scoreboard bench for regwr_sched with a queue-based model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_regwr_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alu_valid = 1'b0, ld_valid = 1'b0, imm_valid = 1'b0, lnk_valid = 1'b0;
   logic        alu_ready, ld_ready, imm_ready, lnk_ready;
   logic [3:0]  alu_addr = '0, ld_addr = '0, imm_addr = '0;
   logic [31:0] alu_data = '0, ld_data = '0, imm_data = '0, lnk_pc = '0;
   logic        wr_en, pend_valid;
   logic [1:0]  wr_mode;
   logic [3:0]  wr_addr, pend_addr;
   logic [31:0] wr_data, wr_pc;

   regwr_sched #(.DATA_W(32), .ADDR_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
      .imm_valid(imm_valid), .imm_ready(imm_ready), .imm_addr(imm_addr), .imm_data(imm_data),
      .lnk_valid(lnk_valid), .lnk_ready(lnk_ready), .lnk_pc(lnk_pc),
      .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
      .pend_valid(pend_valid), .pend_addr(pend_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  mode;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [31:0] pc;
      logic        pend;
   } beat_t;

   beat_t sbq[$];
   beat_t last_beat;
   int    nchk = 0;
   int    nfail = 0;
   int    m_rr = 0;
   bit    m_busy = 1'b0;
   bit    tb_rst_q = 1'b0;
   logic [3:0] rdy_seen;

   function automatic beat_t mk(input logic [1:0] m, input logic [3:0] a,
                                input logic [31:0] d, input logic [31:0] p, input logic pd);
      beat_t b;
      b.mode = m; b.addr = a; b.data = d; b.pc = p; b.pend = pd;
      return b;
   endfunction

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(posedge clk) tb_rst_q <= rst_n;

   // Monitor: every cycle the DUT must present exactly the head of the queue, or hold.
   always @(negedge clk) begin
      beat_t e;
      if (!tb_rst_q) begin
         check("reset_outputs", {wr_en, wr_mode, wr_addr, wr_data, wr_pc, pend_valid, pend_addr}, '0);
         last_beat = mk(2'b00, 4'd0, 32'd0, 32'd0, 1'b0);
      end else if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check("wr_en_beat", wr_en, 1'b1);
         check("beat_fields", {wr_mode, wr_addr, wr_data, pend_valid}, {e.mode, e.addr, e.data, e.pend});
         if (e.mode == 2'b11) check("wr_pc", wr_pc, e.pc);
         if (e.pend) check("pend_addr", pend_addr, e.addr);
         last_beat = e;
      end else begin
         check("idle_hold", {wr_en, pend_valid, wr_mode, wr_addr, wr_data},
               {2'b00, last_beat.mode, last_beat.addr, last_beat.data});
      end
   end

   // Apply one cycle of stimulus, then predict readies and resulting beats.
   task automatic cyc(input bit rn, input bit [3:0] v, input logic [3:0] aa, input logic [3:0] la,
                      input logic [3:0] ia, input logic [31:0] ad, input logic [31:0] ldd,
                      input logic [31:0] idd, input logic [31:0] pc);
      bit [3:0] exp_rdy;
      bit [2:0] req;
      bit       found;
      int       idx;
      @(negedge clk);
      rst_n = rn;
      {lnk_valid, imm_valid, ld_valid, alu_valid} = v;
      alu_addr = aa; ld_addr = la; imm_addr = ia;
      alu_data = ad; ld_data = ldd; imm_data = idd; lnk_pc = pc;
      #1;
      exp_rdy = 4'b0000;
      req = v[2:0];
      if (!rn) begin
         sbq.delete();
         m_busy = 1'b0;
         m_rr = 0;
      end else if (m_busy) begin
         m_busy = 1'b0;
      end else if (v[3]) begin
         exp_rdy[3] = 1'b1;
         sbq.push_back(mk(2'b11, 4'd15, 32'd0, pc, 1'b0));
      end else begin
         found = 1'b0;
         for (int k = 0; k < 3; k++) begin
            idx = (m_rr + k) % 3;
            if (!found && req[idx]) begin
               found = 1'b1;
               exp_rdy[idx] = 1'b1;
               m_rr = (idx + 1) % 3;
               if (idx == 0) sbq.push_back(mk(2'b00, aa, ad, 32'd0, 1'b0));
               else if (idx == 1) sbq.push_back(mk(2'b00, la, ldd, 32'd0, 1'b0));
               else begin
                  sbq.push_back(mk(2'b10, ia, {16'd0, idd[31:16]}, 32'd0, 1'b1));
                  sbq.push_back(mk(2'b01, ia, {16'd0, idd[15:0]}, 32'd0, 1'b0));
                  m_busy = 1'b1;
               end
            end
         end
      end
      rdy_seen = {lnk_ready, imm_ready, ld_ready, alu_ready};
      check("readies", rdy_seen, exp_rdy);
   endtask

   function automatic logic [31:0] r32();
      return $urandom;
   endfunction

   logic [3:0] order_tab [6];

   initial begin
      order_tab[0] = 4'b0001; order_tab[1] = 4'b0010; order_tab[2] = 4'b0100;
      order_tab[3] = 4'b0000; order_tab[4] = 4'b0001; order_tab[5] = 4'b0010;

      // Reset held with every requester asking.
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 4'hF, 4'(r32()), 4'(r32()), 4'(r32()), r32(), r32(), r32(), r32());

      // Continuous ALU/LD/IMM contention straight out of reset.
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 4'b0111, 4'd4, 4'(r32()), 4'(r32()), 32'h5555_5555, r32(), r32(), r32());
         check("grant_order", rdy_seen, order_tab[i]);
      end

      // IMM wins (pointer at IMM) while ALU is held; ALU only gets through after beat 2.
      cyc(1'b1, 4'b0101, 4'd3, 4'd0, 4'd7, r32(), r32(), 32'hDEAD_BEEF, r32());
      check("imm_first", rdy_seen, 4'b0100);
      cyc(1'b1, 4'b0001, 4'd3, 4'd0, 4'd7, r32(), r32(), r32(), r32());
      check("alu_blocked_imm_lo", rdy_seen[0], 1'b0);
      cyc(1'b1, 4'b0001, 4'd3, 4'd0, 4'd7, r32(), r32(), r32(), r32());
      check("alu_after_imm", rdy_seen[0], 1'b1);

      // Link beats ALU, ALU follows.
      cyc(1'b1, 4'b1001, 4'd9, 4'd0, 4'd0, r32(), r32(), r32(), 32'h0000_0100);
      check("link_first", rdy_seen, 4'b1000);
      cyc(1'b1, 4'b0001, 4'd9, 4'd0, 4'd0, r32(), r32(), r32(), r32());
      check("alu_after_link", rdy_seen, 4'b0001);

      // Reset during the low-half cycle of an immediate.
      cyc(1'b1, 4'b0100, 4'd0, 4'd0, 4'd11, r32(), r32(), 32'hCAFE_F00D, r32());
      cyc(1'b0, 4'b0000, 4'd0, 4'd0, 4'd0, r32(), r32(), r32(), r32());
      cyc(1'b1, 4'b0001, 4'd2, 4'd0, 4'd0, 32'h1234_5678, r32(), r32(), r32());
      check("idle_after_reset", rdy_seen, 4'b0001);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 600; i++)
         cyc(($urandom_range(0, 59) != 0), 4'($urandom), 4'(r32()), 4'(r32()), 4'(r32()),
             r32(), r32(), r32(), r32());

      for (int i = 0; i < 4; i++)
         cyc(1'b1, 4'b0000, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
      #1;
      check("queue_drained", 80'(sbq.size()), 80'd0);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
`default_nettype wire
